pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch/next-PC controller for the single-cycle processor datapath. It owns the program counter register and fetches each instruction through a req/ack handshake with instruction memory. It decodes branch/jump control into the 2-bit select for the existing `MUX_PC` block and commits the new PC once per instruction. It sits between the control unit, the instruction memory and `MUX_PC`, and turns the combinational PC path into a sequenced fetch/execute loop.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `FETCH_TIMEOUT`, 15: maximum FETCH cycles without ack before the error state; legal range 1..255.

Ports (clk and reset first):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fetch_req` out 1: instruction fetch request for `pc`.
- `fetch_ack` in 1: instruction memory has the instruction.
- `branch_eq`, `branch_ne`, `jump`, `jump_reg` in 1 each: decoded control, valid only while `instr_valid`=1.
- `zero` in 1: ALU zero flag.
- `stall` in 1: hold the current instruction in EXEC.
- `pc_equal`, `pc_jump`, `crs` in 32 each: branch target, jump target, register target.
- `pc` out 32: current PC.
- `pc_inc` out 32: `pc`+4, combinational.
- `next_pc_sel` out 2: 00 inc, 01 branch, 10 jump, 11 register.
- `next_pc` out 32: `MUX_PC` output.
- `instr_valid` out 1: high in every EXEC cycle.
- `fetch_err` out 1: sticky timeout flag.

## Operation
- States: IDLE, FETCH, EXEC, ERROR, and TRAP when the macro is defined.
- IDLE always moves to FETCH on the next edge.
- FETCH:
  - `fetch_req`=1 and the wait counter increments each cycle.
  - `fetch_ack`=1 moves the block to EXEC and clears the counter.
  - Counter reaching `FETCH_TIMEOUT` with no ack moves the block to ERROR.
  - If ack and timeout occur in the same cycle, ack wins.
- EXEC:
  - `instr_valid`=1 and `next_pc_sel` is driven combinationally.
  - If `stall`=0: `pc`<=`next_pc`, then go to FETCH.
  - If `stall`=1: `pc` holds, the block stays in EXEC, and `next_pc_sel` keeps tracking the inputs.
- ERROR:
  - `fetch_req`=0, `fetch_err`=1, `pc` frozen.
  - Only reset exits.
- Select priority: `jump_reg` > `jump` > branch taken > increment. Branch taken = (`branch_eq`&`zero`) | (`branch_ne`&~`zero`).
- Decode inputs are ignored outside EXEC, where `next_pc_sel`=00.
- `fetch_ack` is ignored outside FETCH.
- Arithmetic: `pc_inc` is a 32-bit add that wraps modulo 2^32, so 32'hFFFF_FFFC+4 gives 0.

## Timing
- Reset values: `pc`=`RESET_PC`, state IDLE, `fetch_req`=0, `instr_valid`=0, `next_pc_sel`=00, `fetch_err`=0.
- Reset asserted mid-FETCH or mid-EXEC aborts immediately. No PC commit occurs.
- `fetch_req` and `instr_valid` are decoded from registered state, so they change only after a clock edge or reset.
- Minimum instruction period is 2 cycles: FETCH with same-cycle ack, then EXEC.
- The PC commits on the edge that ends a non-stalled EXEC cycle. The new `pc` is visible in the following FETCH cycle.
- Timeout: with `FETCH_TIMEOUT`=N and no ack, ERROR is entered on the edge ending the Nth FETCH cycle.

## Configuration
- Macro `PC_MISALIGN_TRAP_EN`:
  - Defined: in EXEC with `stall`=0, a selected target with `next_pc[1:0]`≠00 goes to TRAP instead of committing. Output ports `trap` (1) and `epc` (32) are added. `epc` latches the faulting `pc`, `trap`=1, `fetch_req`=0, and only reset exits. Both outputs reset to 0.
  - Undefined: no TRAP state and no `trap`/`epc` ports. Misaligned targets commit unchanged.

## Structure
- Shared package/header:
  - Select encodings SEL_INC=2'b00, SEL_BEQ=2'b01, SEL_JMP=2'b10, SEL_JR=2'b11.
  - State encodings.
  - `PC_STEP`=4.
- Sub-module: one instance of the existing `MUX_PC` produces `next_pc`. The FSM, counter and PC register live in `pc_sequencer`.

## Test plan
- Reset release with `fetch_ack` tied 1 and no control → `pc` sequence 0,4,8,C, each step taking 2 cycles, with `next_pc_sel`=00.
- EXEC with `branch_eq`=1, `zero`=1, `pc_equal`=32'h40 → `next_pc_sel`=01 and `pc`=40. Repeat with `zero`=0 → `pc`=`pc_inc`.
- EXEC with `jump_reg`=1, `jump`=1, `crs`=32'h100 → `next_pc_sel`=11 and `pc`=100 (priority check).
- `stall`=1 for 3 EXEC cycles → `pc` unchanged, `instr_valid` high for 3 cycles, and the commit happens after stall drops.
- `fetch_ack`=0 with `FETCH_TIMEOUT`=4 → ERROR after 4 FETCH cycles, `fetch_err`=1, `fetch_req`=0. Then `rst_n`=0 → all outputs return to reset values.
- Macro defined, `crs`=32'h102, `jump_reg`=1 → `trap`=1, `epc`=faulting `pc`, and `pc` not updated.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the fetch/next-PC controller.
// State list gains TRAP when PC_MISALIGN_TRAP_EN is defined.
package pc_sequencer_pkg;

  localparam logic [1:0]  SEL_INC = 2'b00;
  localparam logic [1:0]  SEL_BEQ = 2'b01;
  localparam logic [1:0]  SEL_JMP = 2'b10;
  localparam logic [1:0]  SEL_JR  = 2'b11;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_ERROR
`ifdef PC_MISALIGN_TRAP_EN
    ,
    ST_TRAP
`endif
  } state_t;

endpackage

// File: rtl/pc_sequencer_mux_pc.sv
// MUX_PC: 4-way next-PC selector driven by the sequencer's 2-bit select.
module MUX_PC
  import pc_sequencer_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [31:0] pc_inc,
  input  logic [31:0] pc_equal,
  input  logic [31:0] pc_jump,
  input  logic [31:0] crs,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_inc;
    case (sel)
      SEL_INC: next_pc = pc_inc;
      SEL_BEQ: next_pc = pc_equal;
      SEL_JMP: next_pc = pc_jump;
      SEL_JR:  next_pc = crs;
      default: next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/next-PC controller: owns the PC, runs the fetch handshake and commits once per instruction.
// Optional misaligned-target trap (adds trap/epc ports) under `define PC_MISALIGN_TRAP_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        zero,
  input  logic        stall,
  input  logic [31:0] pc_equal,
  input  logic [31:0] pc_jump,
  input  logic [31:0] crs,
  output logic [31:0] pc,
  output logic [31:0] pc_inc,
  output logic [1:0]  next_pc_sel,
  output logic [31:0] next_pc,
  output logic        instr_valid,
  output logic        fetch_err
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic        trap,
  output logic [31:0] epc
`endif
);

  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic        pc_commit;
  logic        branch_taken;
`ifdef PC_MISALIGN_TRAP_EN
  logic        epc_load;
`endif

  assign pc_inc       = pc + PC_STEP;
  assign branch_taken = (branch_eq & zero) | (branch_ne & ~zero);

  // Select is kept in its own process so the FSM can read next_pc without a comb loop.
  always_comb begin
    next_pc_sel = SEL_INC;
    if (state == ST_EXEC) begin
      if (jump_reg)          next_pc_sel = SEL_JR;
      else if (jump)         next_pc_sel = SEL_JMP;
      else if (branch_taken) next_pc_sel = SEL_BEQ;
      else                   next_pc_sel = SEL_INC;
    end
  end

  MUX_PC u_mux_pc (
    .sel      (next_pc_sel),
    .pc_inc   (pc_inc),
    .pc_equal (pc_equal),
    .pc_jump  (pc_jump),
    .crs      (crs),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pc_commit    = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    epc_load     = 1'b0;
`endif
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        // Ack is tested first so it wins over a same-cycle timeout.
        if (fetch_ack) begin
          state_nxt    = ST_EXEC;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
          if (wait_cnt == WAIT_LAST) state_nxt = ST_ERROR;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (next_pc[1:0] != 2'b00) begin
            state_nxt = ST_TRAP;
            epc_load  = 1'b1;
          end else begin
            state_nxt = ST_FETCH;
            pc_commit = 1'b1;
          end
`else
          state_nxt = ST_FETCH;
          pc_commit = 1'b1;
`endif
        end
      end
      ST_ERROR: state_nxt = ST_ERROR;
`ifdef PC_MISALIGN_TRAP_EN
      ST_TRAP:  state_nxt = ST_TRAP;
`endif
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      pc       <= RESET_PC;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (pc_commit) pc <= next_pc;
    end
  end

  assign fetch_req   = (state == ST_FETCH);
  assign instr_valid = (state == ST_EXEC);
  assign fetch_err   = (state == ST_ERROR);

`ifdef PC_MISALIGN_TRAP_EN
  assign trap = (state == ST_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        epc <= '0;
    else if (epc_load) epc <= pc;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps plus randomized instructions vs. a PC model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, fetch_ack;
  logic        branch_eq, branch_ne, jump, jump_reg, zero, stall;
  logic [31:0] pc_equal, pc_jump, crs;
  logic [31:0] pc, pc_inc, next_pc;
  logic [1:0]  next_pc_sel;
  logic        instr_valid, fetch_err;
`ifdef PC_MISALIGN_TRAP_EN
  logic        trap;
  logic [31:0] epc;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC      (RST_PC),
    .FETCH_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_ack   (fetch_ack),
    .branch_eq   (branch_eq),
    .branch_ne   (branch_ne),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .zero        (zero),
    .stall       (stall),
    .pc_equal    (pc_equal),
    .pc_jump     (pc_jump),
    .crs         (crs),
    .pc          (pc),
    .pc_inc      (pc_inc),
    .next_pc_sel (next_pc_sel),
    .next_pc     (next_pc),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .trap        (trap),
    .epc         (epc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: priority jump_reg > jump > taken branch > sequential.
  function automatic logic [1:0] model_sel(input logic beq, bne, j, jr, z);
    if (jr) return 2'd3;
    if (j) return 2'd2;
    if ((beq && z) || (bne && !z)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_target(input logic [1:0] s, input logic [31:0] cur,
                                               input logic [31:0] pe, pj, rs);
    case (s)
      2'd1:    return pe;
      2'd2:    return pj;
      2'd3:    return rs;
      default: return 32'((64'(cur) + 64'd4) % 64'h1_0000_0000);
    endcase
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_req"}, 32'(fetch_req), 32'd0);
    chk({tag, "_iv"}, 32'(instr_valid), 32'd0);
    chk({tag, "_sel"}, 32'(next_pc_sel), 32'd0);
    chk({tag, "_err"}, 32'(fetch_err), 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
    chk({tag, "_trap"}, 32'(trap), 32'd0);
    chk({tag, "_epc"}, epc, 32'd0);
`endif
  endtask

  // Releases reset just after an edge, checks the single IDLE cycle, returns at the start of FETCH.
  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    fetch_ack = 1'b1;
    @(negedge clk);
    chk("idle_req", 32'(fetch_req), 32'd0);
    chk("idle_iv", 32'(instr_valid), 32'd0);
    chk("idle_pc", pc, RST_PC);
    @(posedge clk); #1;
    exp_pc = RST_PC;
  endtask

  // One instruction from the first FETCH cycle through commit; decode is scrambled while fetching.
  task automatic do_instr(input logic beq, bne, j, jr, z, input logic [31:0] pe, pj, rs,
                          input int unsigned ack_wait, input int unsigned stall_cyc);
    logic [1:0] s;
    for (int unsigned i = 0; i <= ack_wait; i++) begin
      fetch_ack = (i == ack_wait);
      {branch_eq, branch_ne, jump, jump_reg, zero, stall} = 6'($urandom);
      pc_equal = pe; pc_jump = pj; crs = rs;
      @(negedge clk);
      chk("fetch_req", 32'(fetch_req), 32'd1);
      chk("fetch_iv", 32'(instr_valid), 32'd0);
      chk("fetch_sel", 32'(next_pc_sel), 32'd0);
      chk("fetch_pc", pc, exp_pc);
      chk("fetch_next", next_pc, model_target(2'd0, exp_pc, pe, pj, rs));
      @(posedge clk); #1;
    end
    {branch_eq, branch_ne, jump, jump_reg} = {beq, bne, j, jr};
    for (int unsigned i = 0; i <= stall_cyc; i++) begin
      fetch_ack = 1'($urandom);
      stall = (i != stall_cyc);
      zero  = (i == stall_cyc) ? z : 1'($urandom);
      s = model_sel(beq, bne, j, jr, zero);
      @(negedge clk);
      chk("exec_iv", 32'(instr_valid), 32'd1);
      chk("exec_req", 32'(fetch_req), 32'd0);
      chk("exec_pc", pc, exp_pc);
      chk("exec_inc", pc_inc, model_target(2'd0, exp_pc, pe, pj, rs));
      chk("exec_sel", 32'(s), 32'(next_pc_sel) ^ 32'd0);
      chk("exec_next", next_pc, model_target(s, exp_pc, pe, pj, rs));
      @(posedge clk); #1;
    end
    exp_pc = model_target(model_sel(beq, bne, j, jr, z), exp_pc, pe, pj, rs);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    fetch_ack = 1'b1;
    {branch_eq, branch_ne, jump, jump_reg, zero, stall} = '0;
    pc_equal = '0; pc_jump = '0; crs = '0;
    exp_pc = RST_PC;
    #2;
    chk_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    release_reset();

    // Sequential fetch: 0,4,8,C with immediate ack
    for (int unsigned k = 0; k < 4; k++) begin
      do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
      chk("seq_pc", exp_pc, 32'(4 * (k + 1))) ;
    end

    // Branch taken / not taken
    do_instr(1, 0, 0, 0, 1, 32'h40, 32'h80, 32'hC0, 0, 0);
    do_instr(1, 0, 0, 0, 0, 32'h400, 32'h80, 32'hC0, 1, 0);
    do_instr(0, 1, 0, 0, 0, 32'h200, 32'h80, 32'hC0, 0, 0);
    // jump_reg beats jump
    do_instr(0, 0, 1, 1, 0, 32'h40, 32'h80, 32'h100, 0, 0);
    do_instr(1, 0, 1, 0, 1, 32'h40, 32'h300, 32'h100, 0, 0);
    // Stall for 3 EXEC cycles, then commit
    do_instr(0, 0, 1, 0, 0, 32'h0, 32'h500, 32'h0, 0, 3);
    // Ack in the same cycle the timeout would fire
    do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 3, 0);
    // Wraparound: FFFF_FFFC + 4 -> 0
    do_instr(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, 0, 0);
    do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);

    for (int unsigned k = 0; k < 40; k++) begin
      do_instr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
               $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Timeout: 4 FETCH cycles without ack
    fetch_ack = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_req", 32'(fetch_req), 32'd1);
      chk("to_err", 32'(fetch_err), 32'd0);
      @(posedge clk); #1;
    end
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_flag", 32'(fetch_err), 32'd1);
      chk("err_req", 32'(fetch_req), 32'd0);
      chk("err_iv", 32'(instr_valid), 32'd0);
      chk("err_pc", pc, exp_pc);
      fetch_ack = 1'b1;
      {branch_eq, branch_ne, jump, jump_reg, zero, stall} = 6'($urandom);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_err");
    release_reset();

    // Reset in the middle of EXEC: no commit
    do_instr(0, 0, 1, 0, 0, 32'h0, 32'h700, 32'h0, 0, 0);
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    {branch_eq, branch_ne, jump, jump_reg, stall} = 5'b00100;
    pc_jump = 32'h900;
    @(negedge clk);
    chk("mid_iv", 32'(instr_valid), 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_outputs("rst_exec");
    @(posedge clk); #1;
    chk("rst_exec_hold", pc, RST_PC);
    release_reset();

`ifdef PC_MISALIGN_TRAP_EN
    do_instr(0, 0, 1, 0, 0, 32'h0, 32'h20, 32'h0, 0, 0);
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    {branch_eq, branch_ne, jump, jump_reg, stall} = 5'b00010;
    crs = 32'h102;
    @(negedge clk);
    chk("trap_sel", 32'(next_pc_sel), 32'd3);
    @(posedge clk); #1;
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("trap_flag", 32'(trap), 32'd1);
      chk("trap_epc", epc, exp_pc);
      chk("trap_pc", pc, exp_pc);
      chk("trap_req", 32'(fetch_req), 32'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1 chk_reset_outputs("rst_trap");
    release_reset();
`else
    // Misaligned targets commit unchanged without the trap feature
    do_instr(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h102, 0, 0);
    do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    chk("misalign_pc", pc, 32'h106);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
